// File: rtl/hpsdr_pkg.sv
// Shared definitions for the HPSDR UDP transmit path: scheduler state encodings
// and the fixed requester slot assignments.
package hpsdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int REQ_DISCOVERY = 0;
  localparam int REQ_IQ        = 1;
  localparam int REQ_WIDEBAND  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/udp_send_scheduler_rr_priority_pick.sv
// Combinational winner select: slot 0 always wins when eligible, otherwise the
// first eligible slot scanning upward from rr_ptr_i over 1..NUM_REQ-1.
module rr_priority_pick #(
  parameter  int NUM_REQ = 4,
  localparam int SW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [SW-1:0]      rr_ptr_i,
  output logic [SW-1:0]      winner_o,
  output logic               valid_o
);

  logic [SW:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    if (elig_i[0]) begin
      valid_o = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ - 1; off++) begin
        idx = {1'b0, rr_ptr_i} + (SW+1)'(off);
        // Wrap past the top slot back to 1; slot 0 never takes part in the scan.
        if (idx >= (SW+1)'(NUM_REQ)) idx = idx - (SW+1)'(NUM_REQ - 1);
        if (!valid_o && elig_i[idx[SW-1:0]]) begin
          valid_o  = 1'b1;
          winner_o = idx[SW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/udp_send_scheduler.sv
// Shares the single UDP sender between NUM_REQ packet sources: start pulse,
// busy tracking, inter-packet gap and start/send watchdogs.
module udp_send_scheduler
  import hpsdr_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int GAP_CYCLES    = 12,
  parameter  int START_TIMEOUT = 1024,
  parameter  int SEND_TIMEOUT  = 125_000_000,
  localparam int SW            = $clog2(NUM_REQ)
) (
  input  logic               tx_clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               run,
  input  logic               tx_busy,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] grant,
  output logic [SW-1:0]      sel,
  output logic               send_start,
  output logic               timeout_err
);

  localparam int TMAX = max3(SEND_TIMEOUT, START_TIMEOUT, GAP_CYCLES);
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [SW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  ack_q, grant_q, onehot_d, elig;
  logic [SW-1:0]       sel_q, pick_idx;
  logic                send_start_q, timeout_err_q, pick_valid;

  always_comb begin
    elig                = run ? req : '0;
    elig[REQ_DISCOVERY] = req[REQ_DISCOVERY];
  end

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    onehot_d = NUM_REQ'(1) << pick_idx;
    rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? SW'(1) : pick_idx + SW'(1);
  end

  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= SW'(1);
      ack_q         <= '0;
      grant_q       <= '0;
      sel_q         <= '0;
      send_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_q         <= '0;
      send_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
      case (state_q)
        ST_IDLE: begin
          // A sender still busy from elsewhere blocks any new grant.
          if (pick_valid && !tx_busy) begin
            state_q      <= ST_START;
            cnt_q        <= '0;
            grant_q      <= onehot_d;
            ack_q        <= onehot_d;
            sel_q        <= pick_idx;
            send_start_q <= 1'b1;
            if (pick_idx != '0) rr_ptr_q <= rr_ptr_d;
          end
        end
        ST_START: begin
          if (!send_start_q && tx_busy) begin
            state_q <= ST_SEND;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
            state_q       <= ST_GAP;
            cnt_q         <= '0;
            grant_q       <= '0;
            timeout_err_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
            grant_q <= '0;
          end else if (cnt_q == CW'(SEND_TIMEOUT - 1)) begin
            state_q       <= ST_GAP;
            cnt_q         <= '0;
            grant_q       <= '0;
            timeout_err_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign sel         = sel_q;
  assign send_start  = send_start_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_udp_send_scheduler.sv
// Bench for udp_send_scheduler: timestamp-based reference model checked every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_udp_send_scheduler;

  localparam int NR    = 4;
  localparam int GAP   = 12;
  localparam int STO   = 1024;
  localparam int SNDTO = 200;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic          run;
  logic          tx_busy;
  logic [NR-1:0] ack, grant;
  logic [1:0]    sel;
  logic          send_start, timeout_err;

  logic snd_busy = 1'b0;
  logic frc_busy = 1'b0;
  int   sndr_dly = 3;
  int   sndr_len = 50;
  int   sc = -1;

  int n_cmp = 0;
  int n_err = 0;
  int tb_cyc = 0;
  int n_terr = 0;
  bit chk_en = 1'b0;

  assign tx_busy = snd_busy | frc_busy;

  udp_send_scheduler #(
    .NUM_REQ(NR), .GAP_CYCLES(GAP), .START_TIMEOUT(STO), .SEND_TIMEOUT(SNDTO)
  ) dut (
    .tx_clock(clk), .reset(reset), .req(req), .run(run), .tx_busy(tx_busy),
    .ack(ack), .grant(grant), .sel(sel), .send_start(send_start),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc++;

  // Sender emulation: busy rises sndr_dly cycles after the start pulse and
  // falls sndr_len cycles later (negative values mean never).
  always @(negedge clk) begin
    if (reset) begin
      sc = -1;
      snd_busy = 1'b0;
    end else if (send_start) begin
      sc = 0;
    end else if (sc >= 0) begin
      sc++;
    end
    if (sc >= 0 && sndr_dly >= 0) begin
      if (sc == sndr_dly) snd_busy = 1'b1;
      if (sndr_len >= 0 && sc >= sndr_dly + sndr_len) begin
        snd_busy = 1'b0;
        sc = -1;
      end
    end
  end

  // Reference model, in terms of packet timestamps rather than states.
  logic [NR-1:0] e_ack = '0, e_grant = '0;
  logic [1:0]    e_sel = '0;
  logic          e_ss = 1'b0, e_terr = 1'b0;
  int m_cyc = 0, m_rr = 1, t_ss = -1, t_rise = -1, t_gap = -1, m_w;

  function automatic int pick(input logic [NR-1:0] r, input logic rn, input int ptr);
    int i;
    if (r[0]) return 0;
    if (!rn) return -1;
    for (int k = 0; k < NR - 1; k++) begin
      i = 1 + (ptr - 1 + k) % (NR - 1);
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_ack = '0; e_grant = '0; e_sel = '0; e_ss = 1'b0; e_terr = 1'b0;
      m_rr = 1; t_ss = -1; t_rise = -1; t_gap = -1;
    end else begin
      e_ack = '0; e_ss = 1'b0; e_terr = 1'b0;
      if (t_gap >= 0) begin
        if (m_cyc + 1 - t_gap == GAP) t_gap = -1;
      end else if (t_ss >= 0) begin
        if (t_rise < 0) begin
          if (m_cyc > t_ss && tx_busy) t_rise = m_cyc + 1;
          else if (m_cyc + 1 - t_ss == STO) begin e_terr = 1'b1; t_gap = m_cyc + 1; end
        end else begin
          if (!tx_busy) t_gap = m_cyc + 1;
          else if (m_cyc + 1 - t_rise == SNDTO) begin e_terr = 1'b1; t_gap = m_cyc + 1; end
        end
        if (t_gap >= 0) begin e_grant = '0; t_ss = -1; t_rise = -1; end
      end else if (!tx_busy) begin
        m_w = pick(req, run, m_rr);
        if (m_w >= 0) begin
          e_grant = NR'(1) << m_w;
          e_ack   = e_grant;
          e_sel   = 2'(m_w);
          e_ss    = 1'b1;
          t_ss    = m_cyc + 1;
          if (m_w > 0) m_rr = (m_w == NR - 1) ? 1 : m_w + 1;
        end
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (timeout_err) n_terr++;
    if (chk_en) begin
      n_cmp++;
      if ({ack, grant, sel, send_start, timeout_err} !== {e_ack, e_grant, e_sel, e_ss, e_terr}) begin
        n_err++;
        $display("FAIL cycle_cmp @%0d: got ack=%b grant=%b sel=%0d ss=%b terr=%b, expected ack=%b grant=%b sel=%0d ss=%b terr=%b",
                 tb_cyc, ack, grant, sel, send_start, timeout_err, e_ack, e_grant, e_sel, e_ss, e_terr);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // kind: 0 = send_start, 1 = ack, 2 = timeout_err. Returns cycle and ack index.
  task automatic wait_pulse(input int kind, input int budget, output int t, output int idx);
    t = -1; idx = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((kind == 0 && send_start) || (kind == 1 && ack != '0) || (kind == 2 && timeout_err)) begin
        t = tb_cyc;
        for (int j = 0; j < NR; j++) if (ack[j]) idx = j;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_pulse kind %0d: none within %0d cycles", kind, budget);
    end
  endtask

  int t0, ts, tt, ix;
  int exp_rr[4] = '{1, 2, 3, 1};

  initial begin
    reset = 1'b1; req = '0; run = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({ack, grant, sel, send_start, timeout_err}), 0);
    reset = 1'b0; chk_en = 1'b1;

    // run=0: only requester 0 may win; raising run lets slot 1 in next.
    req = 4'b1110;
    repeat (30) @(negedge clk);
    chk("run0_no_grant", int'(grant), 0);
    req = 4'b1111;
    wait_pulse(1, 20, t0, ix);
    chk("run0_disc_wins", ix, 0);
    req = 4'b1110; run = 1'b1;
    wait_pulse(1, 100, t0, ix);
    chk("run_rise_serves_1", ix, 1);
    req = '0;
    repeat (80) @(negedge clk);

    // Single request: one-cycle latency, grant spans start pulse to busy fall.
    req = 4'b0010; t0 = tb_cyc;
    wait_pulse(0, 20, ts, ix);
    chk("single_latency", ts - t0, 1);
    chk("single_ack", int'(ack), 2);
    req = '0;
    repeat (53) @(negedge clk);
    chk("single_grant_held", int'(grant), 2);
    @(negedge clk);
    chk("single_grant_drop", int'(grant), 0);
    repeat (20) @(negedge clk);
    chk("single_no_timeout", n_terr, 0);

    // Slot 3 alone wraps the round-robin pointer back to 1.
    sndr_dly = 1; sndr_len = 10;
    req = 4'b1000;
    wait_pulse(1, 20, t0, ix);
    chk("slot3_single", ix, 3);
    req = '0;
    repeat (40) @(negedge clk);

    // All requests: 0 dominates while held, then round-robin 1,2,3,1.
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(1, 100, t0, ix);
      chk("all_req_disc", ix, 0);
    end
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(1, 100, t0, ix);
      chk("rr_order", ix, exp_rr[k]);
    end
    req = '0;
    repeat (40) @(negedge clk);

    // Foreign busy holds the scheduler idle.
    frc_busy = 1'b1; req = 4'b0001;
    repeat (10) @(negedge clk);
    chk("foreign_busy_hold", int'(grant), 0);
    frc_busy = 1'b0; t0 = tb_cyc;
    wait_pulse(0, 20, ts, ix);
    chk("foreign_busy_release", ts - t0, 1);
    req = '0;
    repeat (40) @(negedge clk);

    // Start watchdog: busy never rises.
    sndr_dly = -1;
    req = 4'b0100;
    wait_pulse(0, 20, ts, ix);
    req = '0;
    wait_pulse(2, STO + 20, tt, ix);
    chk("start_timeout_at", tt - ts, STO);
    chk("start_timeout_grant", int'(grant), 0);
    sndr_dly = 1; sndr_len = 5;
    req = 4'b0001;
    wait_pulse(0, 40, t0, ix);
    chk("start_timeout_recover", t0 - tt, GAP + 1);
    req = '0;
    repeat (40) @(negedge clk);

    // Send watchdog: busy stuck high after rising 2 cycles into the packet.
    sndr_dly = 2; sndr_len = -1;
    req = 4'b0100;
    wait_pulse(0, 20, ts, ix);
    req = '0;
    wait_pulse(2, SNDTO + 40, tt, ix);
    chk("send_timeout_at", tt - ts, SNDTO + 3);
    chk("send_timeout_grant", int'(grant), 0);
    sndr_len = 5;
    req = 4'b0010;
    wait_pulse(1, 100, t0, ix);
    chk("send_timeout_recover", ix, 1);
    req = '0;
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-packet; the pointer restarts at 1 so slot 1 beats 3.
    sndr_dly = 2; sndr_len = 40;
    req = 4'b0100;
    wait_pulse(0, 20, ts, ix);
    req = '0;
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({ack, grant, sel, send_start, timeout_err}), 0);
    req = 4'b1010;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    wait_pulse(1, 20, t0, ix);
    chk("post_reset_rr", ix, 1);
    req = 4'b1000;
    wait_pulse(1, 100, t0, ix);
    chk("post_reset_slot3", ix, 3);
    req = '0;
    repeat (60) @(negedge clk);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_cmp++; n_err++;
    $display("FAIL global_timeout: bench did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
